mips_datapath_register_scoreboard: RTL and testbench
====================================================

# mips_datapath_register_scoreboard

Tracks register writes that have been issued but not yet retired in the pipelined MIPS datapath. For each of the current instruction's read ports it produces a forwarding select or a stall request. It sits between the register-port decode stage and the execute-stage operand muxes. This block generalises the fixed two-read/one-write port decode: the read-port count, the pipeline depth tracked and the load-result stage are all parameters, and the block carries sequential hazard state.

## Interface
Parameters:
- `READ_PORTS`, 2: number of source-operand read ports checked per issue.
- `ADDR_WIDTH`, 5: register address width.
- `DEPTH`, 3: number of in-flight pipeline stages tracked (stage 0 = youngest).
- `LOAD_STAGE`, 1: first stage at which a load result can be forwarded; must satisfy 0 ≤ `LOAD_STAGE` < `DEPTH`.

Ports:
- `clock` input 1: single clock, rising edge.
- `resetN` input 1: asynchronous active-low reset.
- `issueValid` input 1: decode presents an instruction.
- `issueReady` output 1: instruction accepted this cycle; 0 means stall.
- `readAddr` input `READ_PORTS*ADDR_WIDTH`: source addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- `readEn` input `READ_PORTS`: per-port read enable.
- `writeAddr` input `ADDR_WIDTH`: destination of the issuing instruction.
- `writeEn` input 1: issuing instruction writes a register.
- `writeIsLoad` input 1: destination value comes from memory.
- `flush` input 1: discard all in-flight entries.
- `fwdSel` output `READ_PORTS*$clog2(DEPTH+1)`: per port, 0 = register file, s+1 = forward from stage s.
- `stallCount` output 16: saturating count of stall cycles.

## Operation
- State: `DEPTH` entries of {valid, addr, isLoad}. Every cycle, entries shift from stage s to stage s+1. The entry in stage `DEPTH-1` retires (the register file writes at the end of that cycle).
- Stage 0 load on an accepted issue (`issueValid && issueReady && !flush`): valid = `writeEn && writeAddr!=0`, addr = `writeAddr`, isLoad = `writeIsLoad`.
- Stage 0 otherwise: a bubble (valid=0) is loaded into stage 0.
- Matching, per enabled read port with a nonzero address: find the youngest valid stage s whose addr equals the read address.
  - If a match exists and the entry is ready, `fwdSel` = s+1. A load entry is ready only when s ≥ `LOAD_STAGE`; a non-load entry is always ready.
  - If the youngest match is a non-ready load, the port hazards. Older matches are ignored in this case.
  - No match, read address 0, or `readEn`=0: `fwdSel` = 0.
- Stall: `issueReady` = !(`issueValid` && any port hazards).
- Stall counter: `stallCount` increments on every cycle where `issueValid && !issueReady`, and holds at 0xFFFF.
- Flush:
  - At the next edge, all entries become invalid, including the would-be stage-0 entry; an issue in the same cycle is dropped.
  - In the flush cycle itself, `fwdSel` and `issueReady` are still computed from the current state.
  - `stallCount` is unaffected by flush.
- Register 0 is never tracked and never forwarded.

## Timing
- `issueReady` and `fwdSel` are combinational from current state and inputs, so they are valid in the same cycle as the issue.
- The state update takes one cycle. An instruction accepted at cycle t is in stage s during cycle t+1+s.
- ALU-to-dependent: a dependent issued at t+1 forwards from stage 0 with no stall.
- Load-to-dependent: a dependent issued at t+1 stalls for `LOAD_STAGE` cycles.
- Reset (asynchronous assert, synchronous release):
  - all entries invalid;
  - `stallCount` = 0;
  - `issueReady` = 1 and `fwdSel` = 0, since both derive from the empty state.
- Reset asserted mid-operation discards all in-flight entries immediately.

## Configuration
- Macro: `MIPS_DATAPATH_REGISTER_SCOREBOARD_FORWARD_EN`.
- Defined: forwarding behaves as described above.
- Undefined:
  - `fwdSel` is tied to 0.
  - Any valid matching entry, ALU or load, at any stage, causes a hazard; the instruction stalls until that writer retires.
  - `LOAD_STAGE` is ignored.
  - Matching, flush and counter behaviour are otherwise unchanged.

## Test plan
All scenarios use default parameters with FORWARD_EN defined unless stated.
- Reset: hold `resetN`=0 with random inputs, then release → `issueReady`=1, `fwdSel`=0, `stallCount`=0.
- ALU forward: issue ALU write r5 at t; issue read port0=r5 at t+1 → `issueReady`=1, port0 `fwdSel`=1. Read r5 at t+3 instead → `fwdSel`=3.
- Load-use: issue load to r8 at t; issue read port1=r8 at t+1 → `issueReady`=0, `stallCount`=1. At t+2 → `issueReady`=1, port1 `fwdSel`=2.
- Youngest wins and r0: ALU write r3 at t, ALU write r3 at t+1, read r3 at t+2 → `fwdSel`=1. Write r0 then read r0 → `fwdSel`=0, no stall.
- Flush: load r8 at t; at t+1 assert `flush` with a read of r8 → stall that cycle. At t+2 the read of r8 → `fwdSel`=0, `issueReady`=1.
- FORWARD_EN undefined: ALU write r5 at t; read r5 from t+1 → `issueReady`=0 at t+1, t+2 and t+3, then 1 at t+4; `stallCount`=3.

Source files
------------

// File: rtl/mips_datapath_register_scoreboard.sv
`timescale 1ns/1ps
// Hazard scoreboard: tracks in-flight register writes and produces per-port forwarding selects or a stall.
// Optional forwarding is enabled by defining MIPS_DATAPATH_REGISTER_SCOREBOARD_FORWARD_EN.
module mips_datapath_register_scoreboard #(
   parameter int READ_PORTS = 2,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 1
) (
   input  logic                                    clock,
   input  logic                                    resetN,
   input  logic                                    issueValid,
   output logic                                    issueReady,
   input  logic [READ_PORTS*ADDR_WIDTH-1:0]        readAddr,
   input  logic [READ_PORTS-1:0]                   readEn,
   input  logic [ADDR_WIDTH-1:0]                   writeAddr,
   input  logic                                    writeEn,
   input  logic                                    writeIsLoad,
   input  logic                                    flush,
   output logic [READ_PORTS*$clog2(DEPTH+1)-1:0]   fwdSel,
   output logic [15:0]                             stallCount
);

   localparam int SEL_W = $clog2(DEPTH+1);

   // First stage at which a matching entry may be forwarded; DEPTH means never.
`ifdef MIPS_DATAPATH_REGISTER_SCOREBOARD_FORWARD_EN
   localparam int LoadReady = LOAD_STAGE;
   localparam int AluReady  = 0;
`else
   localparam int LoadReady = (LOAD_STAGE > DEPTH) ? LOAD_STAGE : DEPTH;
   localparam int AluReady  = DEPTH;
`endif

   logic [DEPTH-1:0]      valid_q, valid_d;
   logic [DEPTH-1:0]      isload_q, isload_d;
   logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
   logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
   logic [15:0]           stall_cnt_q, stall_cnt_d;

   logic [READ_PORTS-1:0] hazard;
   logic [ADDR_WIDTH-1:0] rd_addr [READ_PORTS];
   logic                  accept;

   always_comb begin
      hazard = '0;
      fwdSel = '0;
      for (int k = 0; k < READ_PORTS; k++) begin
         rd_addr[k] = readAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
         // Scan oldest to youngest so the youngest match wins.
         for (int s = DEPTH-1; s >= 0; s--) begin
            if (readEn[k] && (rd_addr[k] != '0) && valid_q[s] && (addr_q[s] == rd_addr[k])) begin
               if (s >= (isload_q[s] ? LoadReady : AluReady)) begin
                  hazard[k]                  = 1'b0;
                  fwdSel[k*SEL_W +: SEL_W]   = SEL_W'(s + 1);
               end else begin
                  hazard[k]                  = 1'b1;
                  fwdSel[k*SEL_W +: SEL_W]   = '0;
               end
            end
         end
      end
`ifndef MIPS_DATAPATH_REGISTER_SCOREBOARD_FORWARD_EN
      fwdSel = '0;
`endif
   end

   assign issueReady = !(issueValid && (|hazard));
   assign accept     = issueValid && issueReady && !flush;
   assign stallCount = stall_cnt_q;

   always_comb begin
      valid_d     = '0;
      isload_d    = '0;
      valid_d[0]  = accept && writeEn && (writeAddr != '0);
      isload_d[0] = writeIsLoad;
      addr_d[0]   = writeAddr;
      for (int s = 1; s < DEPTH; s++) begin
         valid_d[s]  = valid_q[s-1];
         isload_d[s] = isload_q[s-1];
         addr_d[s]   = addr_q[s-1];
      end
      if (flush) valid_d = '0;
      stall_cnt_d = stall_cnt_q;
      if (issueValid && !issueReady && (stall_cnt_q != 16'hFFFF))
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         valid_q     <= '0;
         isload_q    <= '0;
         stall_cnt_q <= '0;
         for (int s = 0; s < DEPTH; s++) addr_q[s] <= '0;
      end else begin
         valid_q     <= valid_d;
         isload_q    <= isload_d;
         stall_cnt_q <= stall_cnt_d;
         for (int s = 0; s < DEPTH; s++) addr_q[s] <= addr_d[s];
      end
   end

endmodule

// File: tb/tb_mips_datapath_register_scoreboard.sv
`timescale 1ns/1ps
// Directed plus randomized bench with a list-of-writers reference model.
module tb_mips_datapath_register_scoreboard;

   localparam int RP = 2;
   localparam int AW = 5;
   localparam int DEPTH = 3;
   localparam int LOAD_STAGE = 1;
   localparam int SW = $clog2(DEPTH+1);

   logic              clock, resetN, issueValid, issueReady;
   logic [RP*AW-1:0]  readAddr;
   logic [RP-1:0]     readEn;
   logic [AW-1:0]     writeAddr;
   logic              writeEn, writeIsLoad, flush;
   logic [RP*SW-1:0]  fwdSel;
   logic [15:0]       stallCount;

   mips_datapath_register_scoreboard #(
      .READ_PORTS(RP), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)
   ) dut (
      .clock(clock), .resetN(resetN), .issueValid(issueValid), .issueReady(issueReady),
      .readAddr(readAddr), .readEn(readEn), .writeAddr(writeAddr), .writeEn(writeEn),
      .writeIsLoad(writeIsLoad), .flush(flush), .fwdSel(fwdSel), .stallCount(stallCount)
   );

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   int checks = 0;
   int failures = 0;

   // Reference model: in-flight writers with age = cycles since entering stage 0.
   int       q_age  [$];
   bit [4:0] q_addr [$];
   bit       q_load [$];
   int       m_stall = 0;
   bit       obs_rdy;
   int       obs_fwd0, obs_fwd1;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic void m_port(input bit [4:0] ra, input bit en, output bit hz, output int sel);
      int best;
      hz = 0; sel = 0; best = -1;
      if (!en || ra == 0) return;
      foreach (q_age[i])
         if (q_addr[i] == ra && (best < 0 || q_age[i] < q_age[best])) best = i;
      if (best < 0) return;
`ifdef MIPS_DATAPATH_REGISTER_SCOREBOARD_FORWARD_EN
      if (q_load[best] && q_age[best] < LOAD_STAGE) hz = 1;
      else sel = q_age[best] + 1;
`else
      hz = 1;
`endif
   endfunction

   function automatic void m_clear();
      q_age.delete(); q_addr.delete(); q_load.delete();
   endfunction

   task automatic step(input bit iv, input bit [4:0] ra0, input bit [4:0] ra1, input bit [1:0] re,
                       input bit [4:0] wa, input bit we, input bit wl, input bit fl);
      bit hz0, hz1, m_rdy;
      int sel0, sel1;
      int n_age [$];
      bit [4:0] n_addr [$];
      bit n_load [$];
      issueValid = iv; readAddr = {ra1, ra0}; readEn = re;
      writeAddr = wa; writeEn = we; writeIsLoad = wl; flush = fl;
      #1;
      m_port(ra0, re[0], hz0, sel0);
      m_port(ra1, re[1], hz1, sel1);
      m_rdy = !(iv && (hz0 || hz1));
      obs_rdy = issueReady;
      obs_fwd0 = int'(fwdSel[0 +: SW]);
      obs_fwd1 = int'(fwdSel[SW +: SW]);
      chk("issueReady", int'(issueReady), int'(m_rdy));
      chk("fwdSel0", obs_fwd0, sel0);
      chk("fwdSel1", obs_fwd1, sel1);
      @(posedge clock);
      if (iv && !m_rdy && m_stall < 65535) m_stall++;
      if (fl) m_clear();
      else begin
         foreach (q_age[i])
            if (q_age[i] + 1 < DEPTH) begin
               n_age.push_back(q_age[i] + 1); n_addr.push_back(q_addr[i]); n_load.push_back(q_load[i]);
            end
         if (iv && m_rdy && we && wa != 0) begin
            n_age.push_back(0); n_addr.push_back(wa); n_load.push_back(wl);
         end
         q_age = n_age; q_addr = n_addr; q_load = n_load;
      end
      #1 chk("stallCount", int'(stallCount), m_stall);
      @(negedge clock);
   endtask

   task automatic idle();
      step(0, 0, 0, 2'b00, 0, 0, 0, 0);
   endtask

   task automatic drain();
      repeat (DEPTH + 1) idle();
   endtask

   task automatic rand_inputs();
      issueValid = 1'($urandom); readAddr = RP*AW'($urandom); readEn = RP'($urandom);
      writeAddr = AW'($urandom); writeEn = 1'($urandom); writeIsLoad = 1'($urandom); flush = 1'($urandom);
   endtask

   initial begin
      int base;
      resetN = 0;
      rand_inputs();
      repeat (3) begin
         @(negedge clock);
         rand_inputs();
      end
      #1;
      chk("rst_ready", int'(issueReady), 1);
      chk("rst_fwd", int'(fwdSel), 0);
      chk("rst_stall", int'(stallCount), 0);
      @(negedge clock);
      resetN = 1;
      idle();
      chk("rst_ready_post", int'(obs_rdy), 1);

`ifdef MIPS_DATAPATH_REGISTER_SCOREBOARD_FORWARD_EN
      // ALU forward from stage 0 and stage 2
      step(1, 0, 0, 2'b00, 5, 1, 0, 0);
      step(1, 5, 0, 2'b01, 0, 0, 0, 0);
      chk("alu_fwd_rdy", int'(obs_rdy), 1);
      chk("alu_fwd_s0", obs_fwd0, 1);
      drain();
      step(1, 0, 0, 2'b00, 5, 1, 0, 0);
      idle(); idle();
      step(1, 5, 0, 2'b01, 0, 0, 0, 0);
      chk("alu_fwd_s2", obs_fwd0, 3);
      drain();
      // load-use
      base = int'(stallCount);
      step(1, 0, 0, 2'b00, 8, 1, 1, 0);
      step(1, 0, 8, 2'b10, 0, 0, 0, 0);
      chk("lu_stall_rdy", int'(obs_rdy), 0);
      chk("lu_stall_cnt", int'(stallCount) - base, 1);
      step(1, 0, 8, 2'b10, 0, 0, 0, 0);
      chk("lu_go_rdy", int'(obs_rdy), 1);
      chk("lu_go_fwd", obs_fwd1, 2);
      drain();
      // youngest wins, r0 never tracked
      step(1, 0, 0, 2'b00, 3, 1, 0, 0);
      step(1, 0, 0, 2'b00, 3, 1, 0, 0);
      step(1, 3, 0, 2'b01, 0, 0, 0, 0);
      chk("youngest", obs_fwd0, 1);
      step(1, 0, 0, 2'b00, 0, 1, 1, 0);
      step(1, 0, 0, 2'b11, 0, 0, 0, 0);
      chk("r0_fwd", obs_fwd0, 0);
      chk("r0_rdy", int'(obs_rdy), 1);
      drain();
      // flush
      step(1, 0, 0, 2'b00, 8, 1, 1, 0);
      step(1, 8, 0, 2'b01, 0, 0, 0, 1);
      chk("flush_stall", int'(obs_rdy), 0);
      step(1, 8, 0, 2'b01, 0, 0, 0, 0);
      chk("flush_fwd", obs_fwd0, 0);
      chk("flush_rdy", int'(obs_rdy), 1);
      drain();
`else
      base = int'(stallCount);
      step(1, 0, 0, 2'b00, 5, 1, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         step(1, 5, 0, 2'b01, 0, 0, 0, 0);
         chk("nofwd_stall", int'(obs_rdy), 0);
      end
      step(1, 5, 0, 2'b01, 0, 0, 0, 0);
      chk("nofwd_go", int'(obs_rdy), 1);
      chk("nofwd_fwd", obs_fwd0, 0);
      chk("nofwd_cnt", int'(stallCount) - base, 3);
      drain();
`endif

      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            issueValid = 1; readEn = 2'b11; readAddr = {5'd1, 5'd2};
            #2 resetN = 0;
            #1;
            chk("midrst_ready", int'(issueReady), 1);
            chk("midrst_fwd", int'(fwdSel), 0);
            chk("midrst_stall", int'(stallCount), 0);
            m_clear();
            m_stall = 0;
            @(negedge clock);
            resetN = 1;
         end
         step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              2'($urandom), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
              1'($urandom), 1'($urandom_range(0, 15) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
